// File: rtl/reset_req_pkg.sv
// reset_req_pkg: shared FSM state type and reset-cause bit layout
package reset_req_pkg;
  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_DONE} state_t;
  localparam int CAUSE_W   = 5;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_BTN = 1;
  localparam int CAUSE_SW  = 2;
  localparam int CAUSE_PLL = 3;
  localparam int CAUSE_WDT = 4;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchroniser plus stable-count debouncer for an idle-high, active-low button
module sync_debounce
  import reset_req_pkg::*;
#(
  parameter logic [15:0] COUNT = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);
  logic [1:0]  sync;
  logic        level;
  logic [15:0] cnt;
  logic        hit;
  assign hit  = (sync[1] != level) && (cnt == COUNT - 16'd1);
  assign fall = hit && level;
  // count cycles the synchronised level disagrees with the accepted level; any return restarts the count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], din};
      cnt   <= (sync[1] == level || hit) ? '0 : cnt + 16'd1;
      level <= hit ? sync[1] : level;
    end
endmodule

// File: rtl/reset_req_gen.sv
// reset_req_gen: collects reset sources, stretches EXT_RST_N, handshakes with FABRIC_RESET_N, keeps a sticky cause; RESET_REQ_WDT_EN builds the watchdog
module reset_req_gen
  import reset_req_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  HOLD_CYCLES     = 8'd64,
  parameter logic [31:0] WDT_TIMEOUT     = 32'd50_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN_N,
  input  logic               SW_RST_REQ,
  input  logic               PLL_LOCK,
  input  logic               WDT_EN,
  input  logic               WDT_KICK,
  input  logic               FABRIC_RESET_N,
  input  logic               RST_CAUSE_CLR,
  output logic               EXT_RST_N,
  output logic               BUSY,
  output logic [CAUSE_W-1:0] RST_CAUSE
);
  state_t             state, state_n;
  logic [1:0]         lock_q, fab_q;
  logic               lock_s, fab_s, lock_prev, lock_seen;
  logic               btn_req, pll_req, wdt_req;
  logic [7:0]         hold;
  logic               ack;
  logic [CAUSE_W-1:0] set;
  sync_debounce #(.COUNT(DEBOUNCE_CYCLES)) u_btn (
    .clk (CLK),
    .rst (RST),
    .din (BTN_N),
    .fall(btn_req)
  );
  assign lock_s  = lock_q[1];
  assign fab_s   = fab_q[1];
  assign pll_req = lock_prev && !lock_s && lock_seen;
  assign BUSY    = state != IDLE;
`ifdef RESET_REQ_WDT_EN
  logic [31:0] wdt_cnt;
  assign wdt_req = WDT_EN && !WDT_KICK && state == IDLE && wdt_cnt == WDT_TIMEOUT - 32'd1;
  // watchdog only runs while idle and enabled; a kick on the terminal count suppresses the request
  always_ff @(posedge CLK or posedge RST)
    if (RST) wdt_cnt <= '0;
    else     wdt_cnt <= (!WDT_EN || WDT_KICK || state != IDLE || wdt_req) ? '0 : wdt_cnt + 32'd1;
`else
  logic unused_wdt;
  assign wdt_req    = 1'b0;
  assign unused_wdt = ^{WDT_EN, WDT_KICK, WDT_TIMEOUT};
`endif
  // gather request sources into their cause bit positions
  always_comb begin
    set            = '0;
    set[CAUSE_BTN] = btn_req;
    set[CAUSE_SW]  = SW_RST_REQ;
    set[CAUSE_PLL] = pll_req;
    set[CAUSE_WDT] = wdt_req;
  end
  // sequence: any request starts one stretched pulse; leave ASSERT only after hold time and an observed ack
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (|set ? ASSERT : IDLE) :
              state == ASSERT ? ((hold >= HOLD_CYCLES - 8'd1 && (ack || !fab_s)) ? WAIT_DONE : ASSERT) :
                                (fab_s ? IDLE : WAIT_DONE);
  end
  // state, hold/ack tracking, synchronisers, PLL edge history and sticky cause
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state     <= IDLE;
      hold      <= '0;
      ack       <= 1'b0;
      EXT_RST_N <= 1'b1;
      RST_CAUSE <= CAUSE_W'(1) << CAUSE_POR;
      lock_q    <= 2'b00;
      fab_q     <= 2'b11;
      lock_prev <= 1'b0;
      lock_seen <= 1'b0;
    end else begin
      state     <= state_n;
      EXT_RST_N <= state_n != ASSERT;
      hold      <= state != ASSERT ? 8'd0 : hold + {7'd0, hold != 8'hFF};
      ack       <= state == ASSERT && (ack || !fab_s);
      RST_CAUSE <= (RST_CAUSE_CLR ? '0 : RST_CAUSE) | set;
      lock_q    <= {lock_q[0], PLL_LOCK};
      fab_q     <= {fab_q[0], FABRIC_RESET_N};
      lock_prev <= lock_s;
      lock_seen <= lock_seen || lock_s;
    end
endmodule

// File: tb/tb_reset_req_gen.sv
// tb_reset_req_gen: directed table and sequence checks for reset_req_gen
module tb_reset_req_gen;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_N = 1'b1;
  logic       SW_RST_REQ = 1'b0;
  logic       PLL_LOCK = 1'b0;
  logic       WDT_EN = 1'b0;
  logic       WDT_KICK = 1'b0;
  logic       FABRIC_RESET_N;
  logic       RST_CAUSE_CLR = 1'b0;
  logic       EXT_RST_N;
  logic       BUSY;
  logic [4:0] RST_CAUSE;
  logic       follow = 1'b1;
  logic       fab_force = 1'b1;
  logic       ext_dly;
  int         errors = 0;
  int         checks = 0;
  typedef struct {
    logic       sw;
    logic       clr;
    logic       ext;
    logic       busy;
    logic [4:0] cause;
  } vec_t;
  vec_t tbl[7];
  reset_req_gen #(
    .DEBOUNCE_CYCLES(16'd16),
    .HOLD_CYCLES    (8'd64),
    .WDT_TIMEOUT    (32'd100)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .BTN_N         (BTN_N),
    .SW_RST_REQ    (SW_RST_REQ),
    .PLL_LOCK      (PLL_LOCK),
    .WDT_EN        (WDT_EN),
    .WDT_KICK      (WDT_KICK),
    .FABRIC_RESET_N(FABRIC_RESET_N),
    .RST_CAUSE_CLR (RST_CAUSE_CLR),
    .EXT_RST_N     (EXT_RST_N),
    .BUSY          (BUSY),
    .RST_CAUSE     (RST_CAUSE)
  );
  always #5 CLK = ~CLK;
  // controller model: FABRIC_RESET_N follows EXT_RST_N one cycle late, or is forced by the bench
  always @(posedge CLK or posedge RST)
    if (RST) ext_dly <= 1'b1;
    else     ext_dly <= EXT_RST_N;
  assign FABRIC_RESET_N = follow ? ext_dly : fab_force;
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_sw;
    SW_RST_REQ = 1'b1;
    step;
    SW_RST_REQ = 1'b0;
  endtask
  task automatic pulse_clr;
    RST_CAUSE_CLR = 1'b1;
    step;
    RST_CAUSE_CLR = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 500) begin
      step;
      n++;
    end
    chk(name, BUSY, 0);
  endtask
  initial begin
    int  n;
    logic prev, seen;
    int  rises;
    tbl[0] = '{sw: 0, clr: 0, ext: 1, busy: 0, cause: 5'b00101};
    tbl[1] = '{sw: 0, clr: 1, ext: 1, busy: 0, cause: 5'b00000};
    tbl[2] = '{sw: 1, clr: 1, ext: 0, busy: 1, cause: 5'b00100};
    tbl[3] = '{sw: 0, clr: 0, ext: 0, busy: 1, cause: 5'b00100};
    tbl[4] = '{sw: 1, clr: 0, ext: 0, busy: 1, cause: 5'b00100};
    tbl[5] = '{sw: 0, clr: 1, ext: 0, busy: 1, cause: 5'b00000};
    tbl[6] = '{sw: 1, clr: 0, ext: 0, busy: 1, cause: 5'b00100};
    repeat (3) step;
    chk("rst_ext", EXT_RST_N, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_cause", RST_CAUSE, 5'b00001);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) step;
    chk("nolock_busy", BUSY, 0);
    chk("nolock_cause", RST_CAUSE, 5'b00001);
    pulse_sw;
    chk("sw_ext0", EXT_RST_N, 0);
    chk("sw_busy1", BUSY, 1);
    n = 0;
    while (!EXT_RST_N && n < 1000) begin
      n++;
      step;
    end
    chk("sw_low_len", n, 64);
    n = 0;
    while (BUSY && n < 100) begin
      n++;
      step;
    end
    chk("sw_busy_tail", n, 4);
    chk("sw_cause", RST_CAUSE, 5'b00101);
    for (int i = 0; i < 7; i++) begin
      SW_RST_REQ    = tbl[i].sw;
      RST_CAUSE_CLR = tbl[i].clr;
      step;
      SW_RST_REQ    = 1'b0;
      RST_CAUSE_CLR = 1'b0;
      chk($sformatf("tbl%0d_ext", i), EXT_RST_N, tbl[i].ext);
      chk($sformatf("tbl%0d_busy", i), BUSY, tbl[i].busy);
      chk($sformatf("tbl%0d_cause", i), RST_CAUSE, tbl[i].cause);
    end
    n = 0;
    while (!EXT_RST_N && n < 1000) begin
      n++;
      step;
    end
    chk("tbl_no_restart_len", n, 60);
    wait_idle("tbl_idle");
    follow    = 1'b0;
    fab_force = 1'b1;
    pulse_sw;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      n += int'(!EXT_RST_N);
      step;
    end
    chk("noack_low_200", n, 200);
    fab_force = 1'b0;
    step;
    chk("noack_ext_a", EXT_RST_N, 0);
    step;
    chk("noack_ext_b", EXT_RST_N, 0);
    step;
    chk("noack_ext_rel", EXT_RST_N, 1);
    fab_force = 1'b1;
    step;
    step;
    chk("noack_busy_held", BUSY, 1);
    step;
    chk("noack_busy_drop", BUSY, 0);
    follow = 1'b1;
    pulse_clr;
    rises = 0;
    prev  = BUSY;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) BTN_N = ~BTN_N;
      step;
      rises += int'(BUSY && !prev);
      prev = BUSY;
    end
    BTN_N = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step;
      rises += int'(BUSY && !prev);
      prev = BUSY;
    end
    BTN_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step;
      rises += int'(BUSY && !prev);
      prev = BUSY;
    end
    chk("btn_one_seq", rises, 1);
    chk("btn_cause", RST_CAUSE, 5'b00010);
    wait_idle("btn_idle");
    pulse_clr;
    PLL_LOCK = 1'b1;
    repeat (5) step;
    chk("pll_rise_norq", BUSY, 0);
    pulse_sw;
    n = 0;
    while (!EXT_RST_N && n < 1000) begin
      if (n == 10) PLL_LOCK = 1'b0;
      n++;
      step;
    end
    chk("pll_no_restart_len", n, 64);
    chk("pll_cause_assert", RST_CAUSE, 5'b01100);
    wait_idle("pll_idle");
    pulse_clr;
    PLL_LOCK = 1'b1;
    repeat (5) step;
    PLL_LOCK = 1'b0;
    repeat (6) step;
    chk("pll_idle_req", BUSY, 1);
    chk("pll_idle_cause", RST_CAUSE, 5'b01000);
    wait_idle("pll_idle2");
`ifdef RESET_REQ_WDT_EN
    WDT_EN = 1'b1;
    seen   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      WDT_KICK = 1'b1;
      step;
      WDT_KICK = 1'b0;
      repeat (89) begin
        step;
        seen |= BUSY;
      end
    end
    chk("wdt_kicked_no_rst", seen, 0);
    pulse_clr;
    WDT_KICK = 1'b1;
    step;
    WDT_KICK = 1'b0;
    n = 0;
    while (EXT_RST_N && n < 300) begin
      step;
      n++;
    end
    chk("wdt_latency", n, 100);
    chk("wdt_cause", RST_CAUSE, 5'b10000);
    wait_idle("wdt_idle");
    WDT_KICK = 1'b1;
    step;
    WDT_KICK = 1'b0;
    repeat (99) step;
    WDT_KICK = 1'b1;
    step;
    WDT_KICK = 1'b0;
    chk("wdt_kick_terminal", BUSY, 0);
    WDT_EN = 1'b0;
`else
    WDT_EN = 1'b1;
    seen   = 1'b0;
    repeat (150) begin
      step;
      seen |= BUSY;
    end
    chk("nowdt_no_rst", seen, 0);
    chk("nowdt_cause4", RST_CAUSE[4], 0);
    WDT_EN = 1'b0;
`endif
    pulse_sw;
    repeat (10) step;
    chk("mid_pre_ext", EXT_RST_N, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_ext", EXT_RST_N, 1);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_cause", RST_CAUSE, 5'b00001);
    @(negedge CLK);
    RST = 1'b0;
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
